mem_if_sram_resp: RTL and testbench
===================================

# mem_if_sram_resp

Responder end of the wide memory interface: accepts level-held requests (`mem_req_vld`, `mem_addr`, `mem_wr_en`/`mem_rd_en`, `mem_wr_data`) from a snapshot-style initiator and returns a single-cycle `mem_ack_vld` with `mem_err`/`mem_rd_data`. Backed by a single-port synchronous SRAM macro with parameterised read latency. Sits between the register-block memory initiators and on-chip SRAM; also keeps saturating access/error counters for debug readout.

## Interface
- `MEM_DATA_WIDTH`, 64, data width of memory interface and SRAM word
- `MEM_ADDR_WIDTH`, 32, word address width on memory interface
- `SRAM_ADDR_WIDTH`, 10, SRAM address width
- `SRAM_DEPTH`, 1024, valid words; legal range 1..2**SRAM_ADDR_WIDTH
- `RD_LATENCY`, 1, SRAM read latency in cycles, legal 1..4
- `CNT_WIDTH`, 16, width of each statistics counter

- `clk`  input  1  clock; one clock domain
- `soft_rst`  input  1  synchronous, active-high reset
- `mem_req_vld`  input  1  request; held high until the ack cycle
- `mem_addr`  input  MEM_ADDR_WIDTH  word address; stable while `mem_req_vld`
- `mem_wr_en`  input  1  write request
- `mem_rd_en`  input  1  read request
- `mem_wr_data`  input  MEM_DATA_WIDTH  write data; stable while `mem_req_vld`
- `mem_ack_vld`  output  1  one-cycle completion pulse
- `mem_err`  output  1  error qualifier, valid only with `mem_ack_vld`
- `mem_rd_data`  output  MEM_DATA_WIDTH  read data, valid only with read ack, else 0
- `sram_cs`  output  1  SRAM chip select, one cycle per access
- `sram_we`  output  1  SRAM write enable, qualified by `sram_cs`
- `sram_addr`  output  SRAM_ADDR_WIDTH  SRAM address
- `sram_wdata`  output  MEM_DATA_WIDTH  SRAM write data
- `sram_rdata`  input  MEM_DATA_WIDTH  SRAM read data, valid RD_LATENCY cycles after `sram_cs` cycle
- `rd_cnt`, `wr_cnt`, `err_cnt`  output  CNT_WIDTH each  saturating counts of completed reads, writes, errored accesses

## Operation
- States: S_IDLE, S_WRITE, S_READ_WAIT, S_ACK, S_ERR (one-hot).
- S_IDLE, `mem_req_vld`=1: decode.
  - Error if `mem_wr_en`==`mem_rd_en` (both or neither) or `mem_addr` >= SRAM_DEPTH → S_ERR; no SRAM access.
  - Else write → S_WRITE; read → S_READ_WAIT. Register `sram_cs`=1, `sram_we`=`mem_wr_en`, `sram_addr`=`mem_addr[SRAM_ADDR_WIDTH-1:0]`, `sram_wdata`=`mem_wr_data`.
- S_WRITE: `sram_cs` high this cycle only; → S_ACK.
- S_READ_WAIT: latency counter loaded with RD_LATENCY at entry, decrements each cycle; on its last cycle capture `sram_rdata` into the read-data register; → S_ACK.
- S_ACK: `mem_ack_vld`=1, `mem_err`=0, `mem_rd_data`=captured data for reads (0 for writes); increment `rd_cnt` or `wr_cnt`; → S_IDLE.
- S_ERR: `mem_ack_vld`=1, `mem_err`=1, `mem_rd_data`=0; increment `err_cnt`; → S_IDLE.
- Only one outstanding access. `mem_req_vld` is not sampled outside S_IDLE. Initiator drops request after the ack edge, so S_IDLE never re-accepts the acked request.
- Counters saturate at all-ones; no wrap.
- `sram_we`, `sram_addr`, `sram_wdata` are 0 whenever `sram_cs`=0.

## Timing
- Reset (`soft_rst`=1 at an edge): state S_IDLE; `mem_ack_vld`, `mem_err`, `mem_rd_data`, `sram_cs`, `sram_we`, `sram_addr`, `sram_wdata`, latency counter, read-data register, all counters = 0. Reset overrides every other event in the same cycle.
- Reset mid-access drops the access. No ack is produced. An in-flight SRAM read result is discarded. A `mem_req_vld` still high after reset release is decoded as a new request.
- T0 = first S_IDLE cycle with `mem_req_vld`=1.
- Write: `sram_cs` in T1, ack in T2. Two-cycle request-to-ack.
- Read: `sram_cs` in T1, data captured at end of T1+RD_LATENCY, ack in T2+RD_LATENCY (RD_LATENCY=1 → ack T3).
- Error: ack+err in T1; `sram_cs` never asserted.
- Back-to-back: next request is accepted earliest in the cycle after the ack cycle.
- All outputs are registered; there is no combinational path from `mem_*` inputs to outputs.

## Test plan
- Write 0xDEAD_BEEF_0123_4567 to addr 5, then read addr 5 → `sram_cs`/`sram_we`=1 in T1 and ack T2 for write; read ack at T3 with `mem_rd_data`=0xDEAD_BEEF_0123_4567, `mem_err`=0; `wr_cnt`=1, `rd_cnt`=1.
- RD_LATENCY=3, read addr 0 → ack exactly 5 cycles after T0, single-cycle pulse, data matches SRAM model.
- Addr 1024 (SRAM_DEPTH=1024), and separately `mem_wr_en`=`mem_rd_en`=1 → ack+err in T1, `sram_cs` never high, `err_cnt`=2.
- `soft_rst` pulsed in S_READ_WAIT with `mem_req_vld` held high → no ack before reset; all outputs 0 after reset; request re-decoded; correct ack follows.
- CNT_WIDTH=2, five writes → `wr_cnt` reaches 3 and holds at 3.
- 100 random back-to-back reads and writes against a reference model → every ack is one cycle wide, data is correct, there is exactly one ack per request, and no ack occurs outside an accepted request.

Source files
------------

// File: rtl/mem_if_sram_resp.sv
// mem_if_sram_resp
// Responder side of the wide memory interface. It takes one level-held
// request at a time, performs it against a single-port synchronous SRAM
// macro and answers with a one-cycle ack pulse carrying an error flag and,
// for reads, the read data. Saturating read/write/error counters are kept
// for debug readout.
//
// Ports
//   clk, soft_rst            clock, synchronous active-high reset
//   mem_req_vld              request, held until the ack cycle
//   mem_addr, mem_wr_en,     word address, write / read enables and write
//   mem_rd_en, mem_wr_data   data, stable while mem_req_vld is high
//   mem_ack_vld, mem_err,    one-cycle completion pulse, error qualifier,
//   mem_rd_data              read data (0 except on a read ack)
//   sram_cs, sram_we,        SRAM strobe (one cycle per access), write
//   sram_addr, sram_wdata    enable, address and write data (0 when idle)
//   sram_rdata               SRAM read data, RD_LATENCY cycles after sram_cs
//   rd_cnt, wr_cnt, err_cnt  saturating counts of completed reads, writes
//                            and errored accesses
module mem_if_sram_resp #(
   parameter int MEM_DATA_WIDTH  = 64,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int SRAM_ADDR_WIDTH = 10,
   parameter int SRAM_DEPTH      = 1024,
   parameter int RD_LATENCY      = 1,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       soft_rst,
   input  logic                       mem_req_vld,
   input  logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
   input  logic                       mem_wr_en,
   input  logic                       mem_rd_en,
   input  logic [MEM_DATA_WIDTH-1:0]  mem_wr_data,
   output logic                       mem_ack_vld,
   output logic                       mem_err,
   output logic [MEM_DATA_WIDTH-1:0]  mem_rd_data,
   output logic                       sram_cs,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [MEM_DATA_WIDTH-1:0]  sram_wdata,
   input  logic [MEM_DATA_WIDTH-1:0]  sram_rdata,
   output logic [CNT_WIDTH-1:0]       rd_cnt,
   output logic [CNT_WIDTH-1:0]       wr_cnt,
   output logic [CNT_WIDTH-1:0]       err_cnt
);

   localparam int LAT_W = 3;  // holds 0..4
   localparam logic [LAT_W-1:0]          LAT_LOAD  = LAT_W'(RD_LATENCY);
   localparam logic [LAT_W-1:0]          LAT_ONE   = LAT_W'(1);
   localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = CNT_WIDTH'(1);
   // One extra bit so the depth limit is representable even when it equals
   // 2**MEM_ADDR_WIDTH.
   localparam logic [MEM_ADDR_WIDTH:0]   DEPTH_LIM = (MEM_ADDR_WIDTH+1)'(SRAM_DEPTH);

   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_WRITE     = 5'b00010,
      S_READ_WAIT = 5'b00100,
      S_ACK       = 5'b01000,
      S_ERR       = 5'b10000
   } state_t;

   state_t                      state_q, state_d;
   logic                        ack_q, ack_d;
   logic                        err_q, err_d;
   logic [MEM_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                        cs_q, cs_d;
   logic                        we_q, we_d;
   logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [MEM_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [LAT_W-1:0]            lat_q, lat_d;
   logic [CNT_WIDTH-1:0]        rd_cnt_q, rd_cnt_d;
   logic [CNT_WIDTH-1:0]        wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0]        err_cnt_q, err_cnt_d;

   logic                        req_bad;

   // Illegal when the enables agree (both or neither) or the word lies
   // beyond the populated part of the SRAM.
   assign req_bad = (mem_wr_en == mem_rd_en) || ({1'b0, mem_addr} >= DEPTH_LIM);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   always_comb begin
      state_d   = state_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rd_data_d = '0;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      lat_d     = lat_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      err_cnt_d = err_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (mem_req_vld) begin
               if (req_bad) begin
                  // Ack and error are registered on entry so they show in S_ERR.
                  state_d   = S_ERR;
                  ack_d     = 1'b1;
                  err_d     = 1'b1;
                  err_cnt_d = sat_inc(err_cnt_q);
               end else begin
                  cs_d    = 1'b1;
                  we_d    = mem_wr_en;
                  addr_d  = mem_addr[SRAM_ADDR_WIDTH-1:0];
                  wdata_d = mem_wr_data;
                  if (mem_wr_en) begin
                     state_d = S_WRITE;
                  end else begin
                     state_d = S_READ_WAIT;
                     lat_d   = LAT_LOAD;
                  end
               end
            end
         end
         S_WRITE: begin
            state_d  = S_ACK;
            ack_d    = 1'b1;
            wr_cnt_d = sat_inc(wr_cnt_q);
         end
         S_READ_WAIT: begin
            // The strobe cycle is the first cycle here, so SRAM data is valid
            // in the cycle where the counter has run down to zero.
            if (lat_q == '0) begin
               state_d   = S_ACK;
               ack_d     = 1'b1;
               rd_data_d = sram_rdata;
               rd_cnt_d  = sat_inc(rd_cnt_q);
            end else begin
               lat_d = lat_q - LAT_ONE;
            end
         end
         S_ACK, S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (soft_rst) begin
         state_q   <= S_IDLE;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lat_q     <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
         cs_q      <= cs_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lat_q     <= lat_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign mem_ack_vld = ack_q;
   assign mem_err     = err_q;
   assign mem_rd_data = rd_data_q;
   assign sram_cs     = cs_q;
   assign sram_we     = we_q;
   assign sram_addr   = addr_q;
   assign sram_wdata  = wdata_q;
   assign rd_cnt      = rd_cnt_q;
   assign wr_cnt      = wr_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mem_if_sram_resp.sv
// Testbench for mem_if_sram_resp: directed cases followed by random
// back-to-back traffic, with a queue-based scoreboard and an SRAM model.
module tb_mem_if_sram_resp;

   localparam int DW    = 64;
   localparam int AW    = 32;
   localparam int SAW   = 10;
   localparam int DEPTH = 1000;
   localparam int LAT   = 3;
   localparam int CW    = 4;
   localparam int MAXC  = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           soft_rst;
   logic           mem_req_vld;
   logic [AW-1:0]  mem_addr;
   logic           mem_wr_en;
   logic           mem_rd_en;
   logic [DW-1:0]  mem_wr_data;
   logic           mem_ack_vld;
   logic           mem_err;
   logic [DW-1:0]  mem_rd_data;
   logic           sram_cs;
   logic           sram_we;
   logic [SAW-1:0] sram_addr;
   logic [DW-1:0]  sram_wdata;
   logic [DW-1:0]  sram_rdata;
   logic [CW-1:0]  rd_cnt;
   logic [CW-1:0]  wr_cnt;
   logic [CW-1:0]  err_cnt;

   mem_if_sram_resp #(
      .MEM_DATA_WIDTH (DW),
      .MEM_ADDR_WIDTH (AW),
      .SRAM_ADDR_WIDTH(SAW),
      .SRAM_DEPTH     (DEPTH),
      .RD_LATENCY     (LAT),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk        (clk),
      .soft_rst   (soft_rst),
      .mem_req_vld(mem_req_vld),
      .mem_addr   (mem_addr),
      .mem_wr_en  (mem_wr_en),
      .mem_rd_en  (mem_rd_en),
      .mem_wr_data(mem_wr_data),
      .mem_ack_vld(mem_ack_vld),
      .mem_err    (mem_err),
      .mem_rd_data(mem_rd_data),
      .sram_cs    (sram_cs),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- SRAM macro model ----------------
   logic [DW-1:0] sram_mem [0:(1<<SAW)-1];
   logic          pv [LAT];
   logic [DW-1:0] pd [LAT];
   logic [DW-1:0] junk;

   always @(posedge clk) begin
      junk <= {$urandom, $urandom};
      for (int i = LAT-1; i > 0; i--) begin
         pv[i] <= soft_rst ? 1'b0 : pv[i-1];
         pd[i] <= pd[i-1];
      end
      pv[0] <= soft_rst ? 1'b0 : (sram_cs === 1'b1 && sram_we === 1'b0);
      pd[0] <= sram_mem[sram_addr];
      if (sram_cs === 1'b1 && sram_we === 1'b1) sram_mem[sram_addr] <= sram_wdata;
   end
   // Outside the valid window the read bus carries noise, so a capture in
   // the wrong cycle shows up as bad data.
   assign sram_rdata = (pv[LAT-1] === 1'b1) ? pd[LAT-1] : junk;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic           err;
      logic [DW-1:0]  data;
      int             t0;
      int             lat;
      logic           we;
      logic [SAW-1:0] saddr;
      logic [DW-1:0]  wdata;
      int             rc;
      int             wc;
      int             ec;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] ref_mem [int];
   int            n_rd, n_wr, n_err;
   int            checks = 0;
   int            errors = 0;
   logic          mon_en = 1'b0;
   logic          prev_ack = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sat(input int v);
      return (v < MAXC) ? v + 1 : v;
   endfunction

   // Expected outcome from the request's rules alone.
   task automatic push_exp(input logic wr, input logic rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
      exp_t e;
      e.err   = (wr == rd) || (addr >= 32'(DEPTH));
      e.t0    = cyc;
      e.we    = wr;
      e.saddr = addr[SAW-1:0];
      e.wdata = data;
      e.data  = '0;
      if (e.err) begin
         e.lat = 1;
         n_err = sat(n_err);
      end else if (wr) begin
         e.lat = 2;
         ref_mem[int'(addr)] = data;
         n_wr = sat(n_wr);
      end else begin
         e.lat  = LAT + 2;
         e.data = ref_mem[int'(addr)];
         n_rd = sat(n_rd);
      end
      e.rc = n_rd;
      e.wc = n_wr;
      e.ec = n_err;
      q.push_back(e);
   endtask

   task automatic issue(input logic wr, input logic rd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
      mem_req_vld = 1'b1;
      mem_wr_en   = wr;
      mem_rd_en   = rd;
      mem_addr    = addr;
      mem_wr_data = data;
      push_exp(wr, rd, addr, data);
   endtask

   task automatic wait_ack();
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_ack_vld === 1'b1) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: no ack within 20 cycles (cycle %0d)", cyc);
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      mem_req_vld = 1'b0;
      mem_wr_en   = 1'($urandom);
      mem_rd_en   = 1'($urandom);
      mem_addr    = $urandom;
      mem_wr_data = {$urandom, $urandom};
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      chk(name, {mem_ack_vld, mem_err, mem_rd_data, sram_cs, sram_we, sram_addr}, '0);
      chk({name, "_sram_wdata"}, sram_wdata, '0);
      chk({name, "_counters"}, {rd_cnt, wr_cnt, err_cnt}, '0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic exp_cs;
      exp_t h;
      if (mon_en) begin
         exp_cs = (q.size() > 0) && !q[0].err && (cyc == q[0].t0 + 1);
         chk("sram_cs", sram_cs, exp_cs);
         if (sram_cs === 1'b1 && exp_cs) begin
            chk("sram_we", sram_we, q[0].we);
            chk("sram_addr", sram_addr, q[0].saddr);
            chk("sram_wdata", sram_wdata, q[0].wdata);
         end else if (sram_cs === 1'b0) begin
            chk("sram_idle_zero", {sram_we, sram_addr, sram_wdata}, '0);
         end

         if (mem_ack_vld === 1'b1) begin
            chk("ack_width", prev_ack, 1'b0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack with no accepted request (cycle %0d)", cyc);
            end else begin
               h = q.pop_front();
               chk("ack_latency", cyc - h.t0, h.lat);
               chk("mem_err", mem_err, h.err);
               chk("mem_rd_data", mem_rd_data, h.data);
               chk("rd_cnt", rd_cnt, h.rc);
               chk("wr_cnt", wr_cnt, h.wc);
               chk("err_cnt", err_cnt, h.ec);
               $display("ack cyc=%0d lat=%0d err=%0b data=%h cnt r/w/e=%0d/%0d/%0d",
                        cyc, cyc - h.t0, mem_err, mem_rd_data, rd_cnt, wr_cnt, err_cnt);
            end
         end else begin
            chk("idle_err", mem_err, 1'b0);
            chk("idle_rd_data", mem_rd_data, '0);
         end
         prev_ack = mem_ack_vld;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   function automatic logic [AW-1:0] valid_addr();
      return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                         : AW'($urandom_range(990, 999));
   endfunction

   initial begin
      logic [AW-1:0] a;
      int r;
      n_rd = 0; n_wr = 0; n_err = 0;
      soft_rst    = 1'b1;
      mem_req_vld = 1'b0;
      mem_wr_en   = 1'b0;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      soft_rst = 1'b0;
      check_zero("reset_state");
      mon_en = 1'b1;

      // Write then read back.
      issue(1, 0, 5, 64'hDEAD_BEEF_0123_4567); wait_ack();
      issue(0, 1, 5, 64'h0);                   wait_ack();
      idle(1);

      // Error cases: out of range, both enables, neither, depth edge, high bits.
      issue(1, 0, 32'd1024, {$urandom, $urandom});  wait_ack();
      issue(1, 1, 32'd7, {$urandom, $urandom});     wait_ack();
      issue(0, 0, 32'd7, {$urandom, $urandom});     wait_ack();
      issue(0, 1, 32'(DEPTH), {$urandom, $urandom}); wait_ack();
      issue(1, 0, 32'h8000_0005, {$urandom, $urandom}); wait_ack();
      idle(2);

      // Prefill the working set back to back; drives wr_cnt into saturation.
      for (int i = 0; i < 16; i++) begin
         issue(1, 0, AW'(i), {$urandom, $urandom}); wait_ack();
      end
      for (int i = 990; i < 1000; i++) begin
         issue(1, 0, AW'(i), {$urandom, $urandom}); wait_ack();
      end
      issue(0, 1, 0, 64'h0);   wait_ack();
      issue(0, 1, 999, 64'h0); wait_ack();
      idle(1);

      // Reset during the read wait with the request held high.
      issue(0, 1, 3, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      soft_rst = 1'b1;
      q.delete();
      n_rd = 0; n_wr = 0; n_err = 0;
      @(posedge clk);
      #1;
      soft_rst = 1'b0;
      check_zero("after_midread_reset");
      push_exp(0, 1, 3, 64'h0);
      wait_ack();

      // Random traffic, mostly back to back.
      for (int n = 0; n < 100; n++) begin
         r = $urandom_range(0, 19);
         if (r < 8)       issue(1, 0, valid_addr(), {$urandom, $urandom});
         else if (r < 16) issue(0, 1, valid_addr(), {$urandom, $urandom});
         else if (r == 16) issue(1, 1, valid_addr(), {$urandom, $urandom});
         else if (r == 17) issue(0, 0, valid_addr(), {$urandom, $urandom});
         else if (r == 18) begin
            a = AW'($urandom_range(DEPTH, DEPTH + 30));
            if ($urandom_range(0, 1) == 0) issue(1, 0, a, {$urandom, $urandom});
            else                           issue(0, 1, a, {$urandom, $urandom});
         end else begin
            a = $urandom | 32'h400;
            issue(0, 1, a, {$urandom, $urandom});
         end
         wait_ack();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      idle(6);
      chk("drain_outstanding", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
